// File: rtl/pwm_peripheral_if.sv
// Register-bank side of the 16-channel PWM peripheral.
// Signals:
//   en_reg_out_7_0 / en_reg_out_15_8 : per-channel output enable
//   en_reg_pwm_7_0 / en_reg_pwm_15_8 : per-channel PWM-mode select (else static high)
//   pwm_duty_cycle                   : shared duty, latched at period boundaries
//   out                              : registered channel outputs
//   period_start                     : one-cycle pulse on the first cycle of each period
interface pwm_peripheral_if;
   logic [7:0]  en_reg_out_7_0;
   logic [7:0]  en_reg_out_15_8;
   logic [7:0]  en_reg_pwm_7_0;
   logic [7:0]  en_reg_pwm_15_8;
   logic [7:0]  pwm_duty_cycle;
   logic [15:0] out;
   logic        period_start;

   // Register bank drives controls and observes outputs.
   modport master (
      output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
             pwm_duty_cycle,
      input  out, period_start
   );

   // The peripheral consumes controls and drives outputs.
   modport slave (
      input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
             pwm_duty_cycle,
      output out, period_start
   );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-channel PWM peripheral with a shared, period-aligned duty cycle.
// A prescaler divides clk by DIV (1..255) into ticks; an 8-bit period counter
// counts ticks, giving a 256*DIV clk period. The duty is shadowed only at the
// period wrap so a period never sees a partial pulse.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pwm_peripheral_if.slave (enables, mode, duty in; out, period_start out)
module pwm_peripheral #(
   parameter int unsigned DIV = 13
) (
   input  logic           clk,
   input  logic           rst_n,
   pwm_peripheral_if.slave bus
);

   localparam int unsigned CW  = 8;
   localparam int unsigned NCH = 16;
   localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = '1;

   logic [CW-1:0]  prescaler;
   logic [CW-1:0]  period_cnt;
   logic [CW-1:0]  duty_shadow;
   logic           tick;
   logic           wrap;
   logic           wrap_q;
   logic           pwm_level;
   logic [NCH-1:0] en_out;
   logic [NCH-1:0] en_pwm;
   logic [NCH-1:0] next_out;
   logic [NCH-1:0] out_q;
   logic           period_start_q;

   assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
   assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

   // Tick on the prescaler's last count; wrap on the last tick of the period.
   assign tick = (prescaler == PRE_LAST);
   assign wrap = tick && (period_cnt == CNT_LAST);

   // Full-scale duty is forced high so 0xFF never drops low for the final tick.
   always_comb begin
      pwm_level = 1'b0;
      if (duty_shadow == CNT_LAST) begin
         pwm_level = 1'b1;
      end else begin
         pwm_level = (period_cnt < duty_shadow);
      end
   end

   // Disabled channels are low; enabled channels are PWM or static high.
   always_comb begin
      next_out = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         if (en_out[i]) begin
            next_out[i] = en_pwm[i] ? pwm_level : 1'b1;
         end
      end
   end

   // Counters free-run regardless of enables so all channels stay phase-aligned.
   // period_start is delayed twice so it lines up with the first out of the period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler      <= '0;
         period_cnt     <= '0;
         duty_shadow    <= '0;
         wrap_q         <= 1'b0;
         out_q          <= '0;
         period_start_q <= 1'b0;
      end else begin
         prescaler <= tick ? '0 : prescaler + 1'b1;
         if (tick) begin
            period_cnt <= period_cnt + 1'b1;
         end
         if (wrap) begin
            duty_shadow <= bus.pwm_duty_cycle;
         end
         wrap_q         <= wrap;
         out_q          <= next_out;
         period_start_q <= wrap_q;
      end
   end

   assign bus.out          = out_q;
   assign bus.period_start = period_start_q;

endmodule
